// File: rtl/output_holder_if.sv
// Byte stream between the XOR stage, the output holder and the user read pin.
// The master drives bytes, the acknowledge pin and flush; the slave (holder) drives status and data.
interface output_holder_if #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) ();
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] cipher_byte;
   logic             cipher_valid;
   logic             cipher_ready;
   logic             output_acknowledge;
   logic             flush;
   logic [WIDTH-1:0] data_out;
   logic             byte_available;
   logic [CW-1:0]    count;
   logic             overflow_err;

   modport master (
      output cipher_byte, cipher_valid, output_acknowledge, flush,
      input  cipher_ready, data_out, byte_available, count, overflow_err
   );

   modport slave (
      input  cipher_byte, cipher_valid, output_acknowledge, flush,
      output cipher_ready, data_out, byte_available, count, overflow_err
   );
endinterface

// File: rtl/output_holder.sv
// Small circular FIFO holding cipher bytes until the user acknowledges each one on an
// asynchronous pin; the head byte feeds the output mux. A companion checker guards count bounds.
module output_holder #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic            clk,
   input  logic            nrst,
   output_holder_if.slave  bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PW-1:0]    wr_ptr_r;
   logic [PW-1:0]    rd_ptr_r;
   logic [CW-1:0]    count_r;
   logic             overflow_r;
   logic             sync1_r;
   logic             sync2_r;
   logic             edge_r;

   logic             full_s;
   logic             empty_s;
   logic             ack_pulse_s;
   logic             push_s;
   logic             pop_s;

   assign full_s      = (count_r == CW'(DEPTH));
   assign empty_s     = (count_r == {CW{1'b0}});
   assign ack_pulse_s = sync2_r & ~edge_r;
   assign push_s      = bus.cipher_valid & ~full_s;
   assign pop_s       = ack_pulse_s & ~empty_s;

   // Acknowledge pin synchroniser plus edge register; deliberately untouched by flush.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         sync1_r <= 1'b0;
         sync2_r <= 1'b0;
         edge_r  <= 1'b0;
      end else begin
         sync1_r <= bus.output_acknowledge;
         sync2_r <= sync1_r;
         edge_r  <= sync2_r;
      end
   end

   // FIFO storage, pointers, occupancy and sticky overflow; flush overrides everything else.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {WIDTH{1'b0}};
         end
         wr_ptr_r   <= {PW{1'b0}};
         rd_ptr_r   <= {PW{1'b0}};
         count_r    <= {CW{1'b0}};
         overflow_r <= 1'b0;
      end else if (bus.flush) begin
         wr_ptr_r   <= {PW{1'b0}};
         rd_ptr_r   <= {PW{1'b0}};
         count_r    <= {CW{1'b0}};
         overflow_r <= 1'b0;
      end else begin
         if (push_s) begin
            mem_r[wr_ptr_r] <= bus.cipher_byte;
            wr_ptr_r        <= wr_ptr_r + PW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PW'(1);
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
         if (bus.cipher_valid && full_s) begin
            overflow_r <= 1'b1;
         end
      end
   end

   // Status and data are decoded from registers only, so they move solely on clock edges.
   assign bus.cipher_ready   = ~full_s;
   assign bus.byte_available = ~empty_s;
   assign bus.count          = count_r;
   assign bus.overflow_err   = overflow_r;
   assign bus.data_out       = empty_s ? {WIDTH{1'b0}} : mem_r[rd_ptr_r];
endmodule

// Occupancy guards: count stays within 0..DEPTH and only steps by one unless flushed.
module output_holder_checker #(
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input logic          clk,
   input logic          nrst,
   input logic          flush,
   input logic [CW-1:0] count
);
   a_count_bound: assert property (@(posedge clk) disable iff (!nrst) count <= CW'(DEPTH));

   a_count_step: assert property (@(posedge clk) disable iff (!nrst)
      !flush |=> (count == $past(count)) || (count == $past(count) + CW'(1)) ||
                 (count == $past(count) - CW'(1)));
endmodule

// File: tb/tb_output_holder.sv
// Directed bench for output_holder: reset, fill/overflow, ack synchronisation, wrap, flush, reset.
module tb_output_holder;
   localparam int DEPTH = 4;
   localparam int WIDTH = 8;

   logic clk;
   logic nrst;
   int   checks;
   int   failures;

   output_holder_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

   output_holder #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
      .clk  (clk),
      .nrst (nrst),
      .bus  (bus.slave)
   );

   output_holder_checker #(.DEPTH(DEPTH)) chk (
      .clk   (clk),
      .nrst  (nrst),
      .flush (bus.flush),
      .count (bus.count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push_byte(input logic [7:0] b);
      bus.cipher_byte  = b;
      bus.cipher_valid = 1'b1;
      tick();
      bus.cipher_valid = 1'b0;
   endtask

   logic [7:0] q[$];
   logic       m_ovf;
   logic       h1, h2, h3, pin, pulse, m_full, m_push, m_pop, vld;
   logic [7:0] b;

   initial begin
      checks = 0;
      failures = 0;
      nrst = 1'b0;
      bus.cipher_byte = 8'h00;
      bus.cipher_valid = 1'b0;
      bus.output_acknowledge = 1'b0;
      bus.flush = 1'b0;
      tick(2);
      nrst = 1'b1;
      tick();

      // 1: reset state and first push
      check_value("rst_ready", 32'(bus.cipher_ready), 32'd1);
      check_value("rst_avail", 32'(bus.byte_available), 32'd0);
      check_value("rst_data", 32'(bus.data_out), 32'h0);
      check_value("rst_count", 32'(bus.count), 32'd0);
      check_value("rst_ovf", 32'(bus.overflow_err), 32'd0);
      push_byte(8'hA5);
      check_value("t1_avail", 32'(bus.byte_available), 32'd1);
      check_value("t1_data", 32'(bus.data_out), 32'hA5);
      check_value("t1_count", 32'(bus.count), 32'd1);
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      check_value("t1_flush_count", 32'(bus.count), 32'd0);

      // 2: fill to DEPTH then overflow
      for (int i = 1; i <= 4; i++) push_byte(8'(i));
      check_value("t2_count", 32'(bus.count), 32'd4);
      check_value("t2_ready", 32'(bus.cipher_ready), 32'd0);
      check_value("t2_data", 32'(bus.data_out), 32'h01);
      push_byte(8'h05);
      check_value("t2_ovf", 32'(bus.overflow_err), 32'd1);
      check_value("t2_count_kept", 32'(bus.count), 32'd4);
      check_value("t2_data_kept", 32'(bus.data_out), 32'h01);

      // 3: held acknowledge pops once, on the third edge after the rise
      bus.output_acknowledge = 1'b1;
      tick(2);
      check_value("t3_no_early_pop", 32'(bus.count), 32'd4);
      tick();
      check_value("t3_pop_count", 32'(bus.count), 32'd3);
      check_value("t3_pop_data", 32'(bus.data_out), 32'h02);
      tick(7);
      check_value("t3_single_pop", 32'(bus.count), 32'd3);
      bus.output_acknowledge = 1'b0;
      tick(3);

      // 5: flush coinciding with a push and an ack pulse
      check_value("t5_pre_ovf", 32'(bus.overflow_err), 32'd1);
      bus.output_acknowledge = 1'b1;
      tick(2);
      bus.flush = 1'b1;
      bus.cipher_valid = 1'b1;
      bus.cipher_byte = 8'h77;
      tick();
      bus.flush = 1'b0;
      bus.cipher_valid = 1'b0;
      check_value("t5_count", 32'(bus.count), 32'd0);
      check_value("t5_ovf", 32'(bus.overflow_err), 32'd0);
      check_value("t5_data", 32'(bus.data_out), 32'h0);
      check_value("t5_ready", 32'(bus.cipher_ready), 32'd1);
      bus.output_acknowledge = 1'b0;
      tick(4);
      check_value("t5_stays_empty", 32'(bus.count), 32'd0);

      // 4: mixed push/pop traffic against a queue model, wrapping pointers
      m_ovf = 1'b0;
      h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
      for (int i = 0; i < 64; i++) begin
         pin = (i % 2) == 1;
         vld = (i < 48) && ((i % 3) != 2);
         b = 8'(8'h10 + i);
         bus.output_acknowledge = pin;
         bus.cipher_valid = vld;
         bus.cipher_byte = b;
         pulse = h2 & ~h3;
         m_full = (q.size() == DEPTH);
         m_push = vld && !m_full;
         m_pop = pulse && (q.size() != 0);
         tick();
         if (m_pop) void'(q.pop_front());
         if (m_push) q.push_back(b);
         if (vld && m_full) m_ovf = 1'b1;
         h3 = h2; h2 = h1; h1 = pin;
         check_value($sformatf("t4_count_%0d", i), 32'(bus.count), 32'(q.size()));
         check_value($sformatf("t4_data_%0d", i), 32'(bus.data_out),
                     (q.size() != 0) ? 32'(q[0]) : 32'h0);
         check_value($sformatf("t4_ready_%0d", i), 32'(bus.cipher_ready),
                     32'(q.size() != DEPTH));
      end
      bus.cipher_valid = 1'b0;
      bus.output_acknowledge = 1'b0;
      check_value("t4_ovf", 32'(bus.overflow_err), 32'(m_ovf));
      check_value("t4_ovf_seen", 32'(m_ovf), 32'd1);
      tick(4);
      check_value("t4_drained", 32'(bus.count), 32'd0);

      // 6: ack edge while empty is not remembered
      bus.output_acknowledge = 1'b1;
      tick(3);
      bus.output_acknowledge = 1'b0;
      tick(3);
      push_byte(8'h3C);
      tick(2);
      check_value("t6_data", 32'(bus.data_out), 32'h3C);
      check_value("t6_count", 32'(bus.count), 32'd1);

      // 6: asynchronous reset while an ack is in flight
      bus.output_acknowledge = 1'b1;
      tick();
      #2;
      nrst = 1'b0;
      #1;
      check_value("t6_rst_count", 32'(bus.count), 32'd0);
      check_value("t6_rst_avail", 32'(bus.byte_available), 32'd0);
      check_value("t6_rst_data", 32'(bus.data_out), 32'h0);
      check_value("t6_rst_ready", 32'(bus.cipher_ready), 32'd1);
      check_value("t6_rst_ovf", 32'(bus.overflow_err), 32'd0);
      bus.output_acknowledge = 1'b0;
      tick();
      nrst = 1'b1;
      tick(4);
      push_byte(8'h5A);
      check_value("t6_post_data", 32'(bus.data_out), 32'h5A);
      check_value("t6_post_count", 32'(bus.count), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
